// File: rtl/voting_pkg.sv
// Shared definitions for the voting machine: FSM state encoding,
// default sizing and a population-count helper for button vectors.
package voting_pkg;

   localparam int unsigned NUM_CANDIDATES_DEF = 4;
   localparam int unsigned CNT_W_DEF          = 31;
   localparam int unsigned LOCKOUT_CYCLES_DEF = 100_000_000;

   // Widest button vector the popcount helper accepts.
   localparam int unsigned MAX_CANDIDATES     = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAST,
      ST_LOCKOUT,
      ST_RESULT
   } ballot_state_t;

   // Number of set bits; callers zero-extend narrower vectors.
   function automatic logic [5:0] count_ones(input logic [MAX_CANDIDATES-1:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < MAX_CANDIDATES; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Parameterised rising-edge detector: one register stage holding the
// previous sample, rise is high while the input is high but was low.
module edge_detect #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] q;

   // Track the previous sample so a held level yields only one pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

   assign rise = d & ~q;

endmodule

// File: rtl/ballot_controller.sv
// Ballot sequencing FSM: officer arms, one clean single-button press
// casts a vote strobe, then a lockout holds off re-arming. Result mode
// is only entered/left from IDLE or ARMED so no vote overlaps results.
module ballot_controller
   import voting_pkg::*;
#(
   parameter int unsigned NUM_CANDIDATES = NUM_CANDIDATES_DEF,
   parameter int unsigned CNT_W          = CNT_W_DEF,
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
   parameter int unsigned ARM_TIMEOUT    = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      mode,
   input  logic                      officer_enable,
   input  logic [NUM_CANDIDATES-1:0] button,
   output logic [NUM_CANDIDATES-1:0] vote_onehot,
   output logic                      valid_vote_casted,
   output logic                      ballot_ready,
   output logic                      busy,
   output logic                      result_mode,
   output logic                      invalid_press,
   output logic                      arm_timeout
);

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   ballot_state_t               state;
   logic [CNT_W-1:0]            cnt;
   logic [CNT_W-1:0]            cnt_inc;
   logic [NUM_CANDIDATES-1:0]   chosen;
   logic [NUM_CANDIDATES-1:0]   button_rise;
   logic [0:0]                  officer_rise;
   logic [5:0]                  ones;
   logic                        any_rise;
   logic                        single_press;
   logic                        multi_press;
   logic                        arm_expired;

   edge_detect #(.WIDTH(NUM_CANDIDATES)) u_button_edge (
      .clock (clock),
      .reset (reset),
      .d     (button),
      .rise  (button_rise)
   );

   edge_detect #(.WIDTH(1)) u_officer_edge (
      .clock (clock),
      .reset (reset),
      .d     (officer_enable),
      .rise  (officer_rise)
   );

   // Press classification is on the whole button level, so a new edge
   // while another button is still held counts as a multi-press.
   assign ones         = count_ones(MAX_CANDIDATES'(button));
   assign any_rise     = |button_rise;
   assign single_press = any_rise && (ones == 6'd1);
   assign multi_press  = any_rise && (ones > 6'd1);
   // >= rather than == so an invalid press winning on the last armed
   // cycle still lets the timeout fire on the following one.
   assign arm_expired  = (ARM_TIMEOUT != 0) && (cnt >= ARM_LAST);
   assign cnt_inc      = (cnt == '1) ? cnt : cnt + CNT_ONE;

   // Ballot FSM with all outputs registered alongside the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: every register, including the latched choice, is cleared
         // by reset so nothing stale can be strobed once reset releases.
         state             <= ST_IDLE;
         cnt               <= '0;
         chosen            <= '0;
         vote_onehot       <= '0;
         valid_vote_casted <= 1'b0;
         ballot_ready      <= 1'b0;
         busy              <= 1'b0;
         result_mode       <= 1'b0;
         invalid_press     <= 1'b0;
         arm_timeout       <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; these defaults make the strobes
         // single-cycle and are overridden by later assignments below.
         vote_onehot       <= '0;
         valid_vote_casted <= 1'b0;
         invalid_press     <= 1'b0;
         arm_timeout       <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (mode) begin
                  state       <= ST_RESULT;
                  result_mode <= 1'b1;
                  cnt         <= '0;
               end else if (officer_rise[0]) begin
                  state        <= ST_ARMED;
                  ballot_ready <= 1'b1;
                  cnt          <= '0;
               end
            end

            ST_ARMED: begin
               if (mode) begin
                  state        <= ST_RESULT;
                  ballot_ready <= 1'b0;
                  result_mode  <= 1'b1;
                  cnt          <= '0;
               end else if (single_press) begin
                  state        <= ST_CAST;
                  chosen       <= button;
                  ballot_ready <= 1'b0;
                  busy         <= 1'b1;
                  cnt          <= '0;
               end else if (multi_press) begin
                  invalid_press <= 1'b1;
                  cnt           <= cnt_inc;
               end else if (arm_expired) begin
                  state        <= ST_IDLE;
                  ballot_ready <= 1'b0;
                  arm_timeout  <= 1'b1;
                  cnt          <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            ST_CAST: begin
               vote_onehot       <= chosen;
               valid_vote_casted <= 1'b1;
               state             <= ST_LOCKOUT;
               cnt               <= '0;
            end

            ST_LOCKOUT: begin
               if ((cnt == LOCK_LAST) && (button == '0)) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt != LOCK_LAST) begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            ST_RESULT: begin
               if (!mode) begin
                  state       <= ST_IDLE;
                  result_mode <= 1'b0;
                  cnt         <= '0;
               end
            end

            default: begin
               state        <= ST_IDLE;
               ballot_ready <= 1'b0;
               busy         <= 1'b0;
               result_mode  <= 1'b0;
               cnt          <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller with a vote scoreboard: expected
// strobes are queued when a valid press is driven and popped when the
// DUT raises valid_vote_casted.
module tb_ballot_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mode = 1'b0;
   logic       officer_enable = 1'b0;
   logic [3:0] button = 4'b0000;

   logic [3:0] vote_onehot;
   logic       valid_vote_casted;
   logic       ballot_ready;
   logic       busy;
   logic       result_mode;
   logic       invalid_press;
   logic       arm_timeout;

   int tests = 0;
   int fails = 0;
   logic [3:0] exp_q[$];

   always #5 clock = ~clock;

   ballot_controller #(
      .NUM_CANDIDATES (4),
      .CNT_W          (31),
      .LOCKOUT_CYCLES (8),
      .ARM_TIMEOUT    (20)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .mode              (mode),
      .officer_enable    (officer_enable),
      .button            (button),
      .vote_onehot       (vote_onehot),
      .valid_vote_casted (valid_vote_casted),
      .ballot_ready      (ballot_ready),
      .busy              (busy),
      .result_mode       (result_mode),
      .invalid_press     (invalid_press),
      .arm_timeout       (arm_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outputs();
      return 32'({vote_onehot, valid_vote_casted, ballot_ready, busy,
                  result_mode, invalid_press, arm_timeout});
   endfunction

   // One clock, then sample 1 ns later and score any vote strobe.
   task automatic step();
      logic [3:0] e;
      @(posedge clock);
      #1;
      if (valid_vote_casted === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_vote", 32'(valid_vote_casted), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("vote_onehot", 32'(vote_onehot), 32'(e));
         end
      end else begin
         check("vote_quiet", 32'(vote_onehot), 32'd0);
      end
   endtask

   task automatic arm();
      officer_enable = 1'b1;
      step();
      officer_enable = 1'b0;
      check("ballot_ready_on_arm", 32'(ballot_ready), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         n++;
         step();
      end
      check("lockout_exit", 32'(busy), 32'd0);
   endtask

   initial begin
      int n;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("reset_outputs", all_outputs(), 32'd0);
      reset = 1'b0;
      step();

      // 1: basic vote, busy length, return to IDLE
      arm();
      button = 4'b0100;
      exp_q.push_back(4'b0100);
      step();
      check("t1_busy_in_cast", 32'(busy), 32'd1);
      check("t1_ready_dropped", 32'(ballot_ready), 32'd0);
      button = 4'b0000;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         step();
      end
      check("t1_busy_cycles", 32'(n), 32'd9);
      check("t1_vote_consumed", 32'(exp_q.size()), 32'd0);
      check("t1_idle_outputs", all_outputs(), 32'd0);

      // 2: button held across arming never counts; held button extends lockout
      button = 4'b0001;
      repeat (3) step();
      arm();
      repeat (4) step();
      check("t2_still_armed", 32'(ballot_ready), 32'd1);
      check("t2_no_busy", 32'(busy), 32'd0);
      button = 4'b0000;
      step();
      button = 4'b0001;
      exp_q.push_back(4'b0001);
      step();
      step();
      repeat (12) step();
      check("t2_held_lockout", 32'(busy), 32'd1);
      button = 4'b0000;
      wait_idle();
      check("t2_vote_consumed", 32'(exp_q.size()), 32'd0);

      // 3: simultaneous two-button press is rejected, then a clean vote
      arm();
      button = 4'b0011;
      step();
      check("t3_invalid_strobe", 32'(invalid_press), 32'd1);
      check("t3_still_armed", 32'(ballot_ready), 32'd1);
      check("t3_no_busy", 32'(busy), 32'd0);
      button = 4'b0000;
      step();
      check("t3_invalid_one_cycle", 32'(invalid_press), 32'd0);
      button = 4'b1000;
      exp_q.push_back(4'b1000);
      step();
      step();
      button = 4'b0000;
      wait_idle();
      check("t3_vote_consumed", 32'(exp_q.size()), 32'd0);

      // 4: armed ballot expires after ARM_TIMEOUT cycles
      arm();
      n = 0;
      while (arm_timeout !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("t4_timeout_cycle", 32'(n), 32'd20);
      check("t4_ready_dropped", 32'(ballot_ready), 32'd0);
      step();
      check("t4_timeout_one_cycle", 32'(arm_timeout), 32'd0);
      check("t4_ready_stays_low", 32'(ballot_ready), 32'd0);

      // 5: result mode cancels an armed ballot and ignores presses/officer
      arm();
      mode = 1'b1;
      step();
      check("t5_result_mode", 32'(result_mode), 32'd1);
      check("t5_ready_cancelled", 32'(ballot_ready), 32'd0);
      button = 4'b0010;
      repeat (3) step();
      officer_enable = 1'b1;
      step();
      officer_enable = 1'b0;
      check("t5_officer_ignored", 32'(ballot_ready), 32'd0);
      check("t5_no_busy", 32'(busy), 32'd0);
      button = 4'b0000;
      mode = 1'b0;
      step();
      check("t5_result_exit", 32'(result_mode), 32'd0);

      // 6a: reset during CAST suppresses the pending strobe
      arm();
      button = 4'b0100;
      step();
      check("t6a_busy_in_cast", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t6a_async_clear", all_outputs(), 32'd0);
      button = 4'b0000;
      step();
      reset = 1'b0;
      repeat (3) step();
      check("t6a_no_busy_after", 32'(busy), 32'd0);

      // 6b: reset two cycles into LOCKOUT, then arming works again
      arm();
      button = 4'b0100;
      exp_q.push_back(4'b0100);
      step();
      step();
      button = 4'b0000;
      step();
      step();
      check("t6b_in_lockout", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t6b_async_clear", all_outputs(), 32'd0);
      step();
      reset = 1'b0;
      step();
      check("t6b_idle_after", all_outputs(), 32'd0);
      arm();
      check("t6b_no_busy_rearmed", 32'(busy), 32'd0);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
